// File: rtl/digi_mod_engine.sv
// Binary digital modulation engine: buffers serial data bits and emits a per-clock
// carrier phase word and amplitude gate for 2ASK, 2FSK, 2PSK and 2DPSK.
module digi_mod_engine #(
    parameter int SYM_LEN = 16,
    parameter int ACC_W   = 16,
    parameter int PW      = 8,
    parameter int FW0     = 4096,
    parameter int FW1     = 8192,
    parameter int FDEPTH  = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          bit_in,
    input  logic          bit_vld,
    input  logic [1:0]    mode,
    output logic [PW-1:0] phase_out,
    output logic          amp_en,
    output logic          sym_start,
    output logic          busy,
    output logic          ovf
);

    localparam int AW = $clog2(FDEPTH);
    localparam int CW = $clog2(SYM_LEN);
    localparam logic [CW-1:0] LAST = CW'(SYM_LEN - 1);
    localparam logic [PW-1:0] HALF = {1'b1, {(PW-1){1'b0}}};

    typedef enum logic [1:0] {M_ASK = 2'd0, M_FSK = 2'd1, M_PSK = 2'd2, M_DPSK = 2'd3} mod_t;
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t           state, state_nx;
    logic [CW-1:0]    cnt, cnt_nx;

    logic [FDEPTH-1:0] fifo_mem;
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [AW:0]       fcount;
    logic              empty, full, wr_en, pop, head;

    logic [ACC_W-1:0]  acc, fw_r, new_fw, step_fw;
    logic              off_r, amp_r, d;
    logic              new_off, new_amp, new_d, step_off, step_amp;
    mod_t              mode_i;

    assign empty  = (fcount == '0);
    assign full   = (fcount == (AW+1)'(FDEPTH));
    assign wr_en  = bit_vld && (!full || pop);
    assign head   = fifo_mem[rd_ptr];
    assign mode_i = mod_t'(mode);

    // NOTE: storage array carries no reset; occupancy is tracked by the reset pointers/count.
    always_ff @(posedge clk) begin
        if (wr_en) fifo_mem[wr_ptr] <= bit_in;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fcount <= '0;
            ovf    <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (pop)   rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, pop})
                2'b10:   fcount <= fcount + (AW+1)'(1);
                2'b01:   fcount <= fcount - (AW+1)'(1);
                default: fcount <= fcount;
            endcase
            if (bit_vld && full && !pop) ovf <= 1'b1;
        end
    end

    // Symbol sequencing; a symbol's parameters are derived from the FIFO head at pop time.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        state_nx = state;
        cnt_nx   = cnt;
        pop      = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop      = 1'b1;
                    state_nx = RUN;
                    cnt_nx   = '0;
                end
            end
            RUN: begin
                if (cnt == LAST) begin
                    if (!empty) begin
                        pop    = 1'b1;
                        cnt_nx = '0;
                    end else begin
                        state_nx = IDLE;
                    end
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        new_d   = d ^ head;
        new_fw  = (mode_i == M_FSK && head) ? ACC_W'(FW1) : ACC_W'(FW0);
        new_amp = (mode_i == M_ASK) ? head : 1'b1;
        case (mode_i)
            M_PSK:   new_off = head;
            M_DPSK:  new_off = new_d;
            default: new_off = 1'b0;
        endcase
        step_fw  = pop ? new_fw  : fw_r;
        step_off = pop ? new_off : off_r;
        step_amp = pop ? new_amp : amp_r;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Accumulator runs only while sampling and is never cleared between symbols.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc       <= '0;
            fw_r      <= '0;
            off_r     <= 1'b0;
            amp_r     <= 1'b0;
            d         <= 1'b0;
            phase_out <= '0;
            amp_en    <= 1'b0;
            sym_start <= 1'b0;
            busy      <= 1'b0;
        end else begin
            if (pop) begin
                fw_r  <= new_fw;
                off_r <= new_off;
                amp_r <= new_amp;
                if (mode_i == M_DPSK) d <= new_d;
            end
            if (state_nx == RUN) begin
                phase_out <= acc[ACC_W-1 -: PW] + (step_off ? HALF : '0);
                acc       <= acc + step_fw;
                amp_en    <= step_amp;
                sym_start <= pop;
                busy      <= 1'b1;
            end else begin
                amp_en    <= 1'b0;
                sym_start <= 1'b0;
                busy      <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_digi_mod_engine.sv
// Self-checking bench for digi_mod_engine: directed scenarios plus random traffic,
// every cycle compared against a queue-based symbol model.
module tb_digi_mod_engine;

    localparam int SYM_LEN = 16;
    localparam int ACC_W   = 16;
    localparam int PW      = 8;
    localparam int FW0     = 4096;
    localparam int FW1     = 8192;
    localparam int FDEPTH  = 4;

    logic          clk, rst, bit_in, bit_vld;
    logic [1:0]    mode;
    logic [PW-1:0] phase_out;
    logic          amp_en, sym_start, busy, ovf;

    digi_mod_engine #(
        .SYM_LEN(SYM_LEN), .ACC_W(ACC_W), .PW(PW),
        .FW0(FW0), .FW1(FW1), .FDEPTH(FDEPTH)
    ) dut (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_vld(bit_vld), .mode(mode),
        .phase_out(phase_out), .amp_en(amp_en), .sym_start(sym_start),
        .busy(busy), .ovf(ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s @%0t: got=0x%0h expected=0x%0h", tag, $time, got, exp);
        end
    endtask

    // Reference model: a queue of waiting bits and a count of samples left in the symbol.
    bit  mq[$];
    int  acc_m, fw_m, rem_m;
    bit  off_m, amp_m, d_m, ovf_m;
    bit  busy_e, amp_e, start_e;
    int  ph_e;

    task automatic model_reset();
        mq.delete();
        acc_m = 0; fw_m = 0; rem_m = 0;
        off_m = 0; amp_m = 0; d_m = 0; ovf_m = 0;
        busy_e = 0; amp_e = 0; start_e = 0; ph_e = 0;
    endtask

    task automatic model_edge(input bit vld, input bit b, input int md);
        bit hb;
        bit popped = 0;
        if (rem_m == 0 && mq.size() > 0) begin
            hb     = mq.pop_front();
            popped = 1;
            fw_m   = (md == 1 && hb) ? FW1 : FW0;
            amp_m  = (md == 0) ? hb : 1'b1;
            if (md == 3) d_m = d_m ^ hb;
            off_m  = (md == 2) ? hb : (md == 3) ? d_m : 1'b0;
            rem_m  = SYM_LEN;
        end
        if (rem_m > 0) begin
            ph_e    = ((acc_m >> (ACC_W - PW)) + (off_m ? (1 << (PW - 1)) : 0)) % (1 << PW);
            acc_m   = (acc_m + fw_m) % (1 << ACC_W);
            busy_e  = 1;
            amp_e   = amp_m;
            start_e = popped;
            rem_m--;
        end else begin
            busy_e = 0; amp_e = 0; start_e = 0;
        end
        if (vld) begin
            if (mq.size() < FDEPTH) mq.push_back(b);
            else ovf_m = 1;
        end
    endtask

    task automatic step(input bit vld, input bit b, input int md);
        logic [11:0] exp_v;
        bit_vld = vld;
        bit_in  = b;
        mode    = 2'(md);
        @(posedge clk);
        model_edge(vld, b, md);
        #1;
        exp_v = {8'(ph_e), amp_e, busy_e, start_e, ovf_m};
        check("out{phase,amp,busy,start,ovf}", {20'd0, phase_out, amp_en, busy, sym_start, ovf},
              {20'd0, exp_v});
    endtask

    task automatic idle(input int n, input int md);
        for (int i = 0; i < n; i++) step(0, 0, md);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear before the next edge.
    task automatic do_reset();
        #3 rst = 1'b0;
        #1 check("rst_outputs", {20'd0, phase_out, amp_en, busy, sym_start, ovf}, 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; bit_in = 1'b0; bit_vld = 1'b0; mode = 2'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 check("reset_state", {20'd0, phase_out, amp_en, busy, sym_start, ovf}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // 2PSK: bits 0,1
        step(1, 0, 2); step(1, 1, 2); idle(40, 2);
        // 2FSK: bits 1,0
        step(1, 1, 1); step(1, 0, 1); idle(40, 1);
        // 2DPSK from reset: bits 1,1,0
        do_reset();
        step(1, 1, 3); step(1, 1, 3); step(1, 0, 3); idle(60, 3);
        // 2ASK: bits 1,0,1
        step(1, 1, 0); step(1, 0, 0); step(1, 1, 0); idle(60, 0);
        // Overflow: six consecutive pushes from IDLE
        for (int i = 0; i < 6; i++) step(1, 1'($urandom_range(0, 1)), 2);
        idle(100, 2);
        check("ovf_sticky", {31'd0, ovf}, 32'd1);
        // Reset during RUN flushes the FIFO
        step(1, 1, 2); step(1, 0, 2); step(1, 1, 2); idle(8, 2);
        do_reset();
        idle(40, 2);

        // Random traffic; mode toggles freely to show it only matters at symbol start
        for (int i = 0; i < 3000; i++) begin
            int r = $urandom_range(0, 99);
            step(r < 12, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
            if (i == 1500) do_reset();
        end
        idle(100, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
